// File: rtl/tug_playfield.sv
// Whole-playfield tug-of-war: one-hot light position, round wins,
// per-player scores, timed re-centre and match latch.
module tug_playfield #(
   parameter int NUM_LIGHTS     = 9,
   parameter int SCORE_WIDTH    = 3,
   parameter int MATCH_POINTS   = 3,
   parameter int RESTART_CYCLES = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   L,
   input  logic                   R,
   output logic [NUM_LIGHTS-1:0]  lights,
   output logic [SCORE_WIDTH-1:0] left_score,
   output logic [SCORE_WIDTH-1:0] right_score,
   output logic                   round_win_l,
   output logic                   round_win_r,
   output logic                   match_over,
   output logic [1:0]             match_winner
);

   localparam int CENTER = (NUM_LIGHTS - 1) / 2;
   localparam int CW     = $clog2(RESTART_CYCLES + 1);
   localparam logic [NUM_LIGHTS-1:0]  CENTER_HOT = NUM_LIGHTS'(1) << CENTER;
   localparam logic [SCORE_WIDTH-1:0] MATCH_PTS  = SCORE_WIDTH'(MATCH_POINTS);
   localparam logic [CW-1:0]          RESTART    = CW'(RESTART_CYCLES);

   typedef enum logic [1:0] {
      PLAY,
      WON,
      DONE
   } state_t;

   state_t                  state, state_n;
   logic [NUM_LIGHTS-1:0]   lights_n;
   logic [SCORE_WIDTH-1:0]  left_n, right_n;
   logic [SCORE_WIDTH-1:0]  left_inc, right_inc;
   logic                    win_l_n, win_r_n;
   logic                    over_n;
   logic [1:0]              winner_n;
   logic [CW-1:0]           cnt, cnt_n;
   logic                    press_l, press_r;

   assign press_l   = L & ~R;
   assign press_r   = R & ~L;
   assign left_inc  = left_score + 1'b1;
   assign right_inc = right_score + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= PLAY;
         lights       <= CENTER_HOT;
         left_score   <= '0;
         right_score  <= '0;
         round_win_l  <= 1'b0;
         round_win_r  <= 1'b0;
         match_over   <= 1'b0;
         match_winner <= 2'b00;
         cnt          <= '0;
      end else begin
         state        <= state_n;
         lights       <= lights_n;
         left_score   <= left_n;
         right_score  <= right_n;
         round_win_l  <= win_l_n;
         round_win_r  <= win_r_n;
         match_over   <= over_n;
         match_winner <= winner_n;
         cnt          <= cnt_n;
      end
   end

   always_comb begin
      state_n  = state;
      lights_n = lights;
      left_n   = left_score;
      right_n  = right_score;
      win_l_n  = 1'b0;
      win_r_n  = 1'b0;
      over_n   = match_over;
      winner_n = match_winner;
      cnt_n    = cnt;
      unique case (state)
         PLAY: begin
            if (press_r) begin
               if (lights[0]) begin
                  lights_n = '0;
                  right_n  = right_inc;
                  win_r_n  = 1'b1;
                  if (right_inc == MATCH_PTS) begin
                     state_n  = DONE;
                     over_n   = 1'b1;
                     winner_n = 2'b10;
                  end else begin
                     state_n = WON;
                     cnt_n   = RESTART;
                  end
               end else begin
                  lights_n = lights >> 1;
               end
            end else if (press_l) begin
               if (lights[NUM_LIGHTS-1]) begin
                  lights_n = '0;
                  left_n   = left_inc;
                  win_l_n  = 1'b1;
                  if (left_inc == MATCH_PTS) begin
                     state_n  = DONE;
                     over_n   = 1'b1;
                     winner_n = 2'b01;
                  end else begin
                     state_n = WON;
                     cnt_n   = RESTART;
                  end
               end else begin
                  lights_n = lights << 1;
               end
            end
         end
         WON: begin
            // Counter reaching 1 ends the dark phase on this edge.
            cnt_n = cnt - 1'b1;
            if (cnt == CW'(1)) begin
               lights_n = CENTER_HOT;
               state_n  = PLAY;
            end
         end
         DONE: begin
            lights_n = '0;
         end
         default: begin
            state_n = PLAY;
         end
      endcase
   end

endmodule

// File: tb/tb_tug_playfield.sv
// Scoreboarded directed bench for tug_playfield with an
// integer-position reference model.
module tb_tug_playfield;

   localparam int N  = 9;
   localparam int SW = 3;
   localparam int MP = 3;
   localparam int RC = 4;
   localparam int C  = (N - 1) / 2;

   logic          clk;
   logic          reset;
   logic          L, R;
   logic [N-1:0]  lights;
   logic [SW-1:0] left_score, right_score;
   logic          round_win_l, round_win_r;
   logic          match_over;
   logic [1:0]    match_winner;

   typedef struct {
      logic [N-1:0]  lights;
      logic [SW-1:0] ls;
      logic [SW-1:0] rs;
      logic          wl;
      logic          wr;
      logic          mo;
      logic [1:0]    mw;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // reference model: pos = -1 means dark
   int         m_pos, m_ls, m_rs, m_cnt, m_st;
   logic       m_wl, m_wr, m_mo;
   logic [1:0] m_mw;

   tug_playfield #(
      .NUM_LIGHTS(N),
      .SCORE_WIDTH(SW),
      .MATCH_POINTS(MP),
      .RESTART_CYCLES(RC)
   ) dut (
      .clk(clk),
      .reset(reset),
      .L(L),
      .R(R),
      .lights(lights),
      .left_score(left_score),
      .right_score(right_score),
      .round_win_l(round_win_l),
      .round_win_r(round_win_r),
      .match_over(match_over),
      .match_winner(match_winner)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_pos = C; m_ls = 0; m_rs = 0; m_cnt = 0; m_st = 0;
      m_wl = 0; m_wr = 0; m_mo = 0; m_mw = 2'b00;
   endtask

   task automatic model_step(input logic l, input logic r);
      m_wl = 0;
      m_wr = 0;
      if (m_st == 0) begin
         if (r && !l) begin
            if (m_pos == 0) begin
               m_rs++; m_wr = 1; m_pos = -1;
               if (m_rs == MP) begin
                  m_st = 2; m_mo = 1; m_mw = 2'b10;
               end else begin
                  m_st = 1; m_cnt = RC;
               end
            end else m_pos--;
         end else if (l && !r) begin
            if (m_pos == N - 1) begin
               m_ls++; m_wl = 1; m_pos = -1;
               if (m_ls == MP) begin
                  m_st = 2; m_mo = 1; m_mw = 2'b01;
               end else begin
                  m_st = 1; m_cnt = RC;
               end
            end else m_pos++;
         end
      end else if (m_st == 1) begin
         if (m_cnt == 1) begin
            m_pos = C; m_st = 0;
         end
         m_cnt--;
      end
   endtask

   function automatic exp_t model_exp();
      exp_t e;
      e.lights = (m_pos < 0) ? '0 : (N'(1) << m_pos);
      e.ls = SW'(m_ls);
      e.rs = SW'(m_rs);
      e.wl = m_wl;
      e.wr = m_wr;
      e.mo = m_mo;
      e.mw = m_mw;
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cmp_all(input string tag, input exp_t e);
      chk({tag, ".lights"}, 32'(lights), 32'(e.lights));
      chk({tag, ".ls"}, 32'(left_score), 32'(e.ls));
      chk({tag, ".rs"}, 32'(right_score), 32'(e.rs));
      chk({tag, ".wl"}, 32'(round_win_l), 32'(e.wl));
      chk({tag, ".wr"}, 32'(round_win_r), 32'(e.wr));
      chk({tag, ".mo"}, 32'(match_over), 32'(e.mo));
      chk({tag, ".mw"}, 32'(match_winner), 32'(e.mw));
   endtask

   task automatic step(input string tag, input logic l, input logic r);
      exp_t e;
      L = l;
      R = r;
      model_step(l, r);
      sb.push_back(model_exp());
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $error("FAIL %s scoreboard empty", tag);
      end else begin
         e = sb.pop_front();
         cmp_all(tag, e);
      end
   endtask

   task automatic async_reset(input string tag);
      reset = 1'b1;
      model_reset();
      #1;
      cmp_all(tag, model_exp());
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      L = 1'b0;
      R = 1'b0;
      reset = 1'b0;
      model_reset();
      #1 reset = 1'b1;
      #1;
      cmp_all("rst0", model_exp());
      chk("rst0.lit", 32'(lights), 32'h010);
      @(posedge clk);
      #1 reset = 1'b0;

      step("r1", 0, 1);
      chk("r1.lit", 32'(lights), 32'h008);
      step("l1", 1, 0);
      chk("l1.lit", 32'(lights), 32'h010);
      for (int i = 0; i < 3; i++) step("lr", 1, 1);
      chk("lr.lit", 32'(lights), 32'h010);
      for (int i = 0; i < 2; i++) step("idle", 0, 0);

      for (int i = 0; i < 5; i++) step("rwin", 0, 1);
      chk("rwin.lit", 32'(lights), 32'h000);
      chk("rwin.rs", 32'(right_score), 32'd1);
      chk("rwin.wr", 32'(round_win_r), 32'd1);
      step("dark0", 1, 0);
      chk("dark0.wr", 32'(round_win_r), 32'd0);
      step("dark1", 0, 1);
      step("dark2", 1, 1);
      chk("dark2.lit", 32'(lights), 32'h000);
      step("dark3", 1, 0);
      chk("recentre", 32'(lights), 32'h010);

      for (int i = 0; i < 4; i++) step("lmove", 1, 0);
      chk("lmax", 32'(lights), 32'h100);
      step("lwin", 1, 0);
      chk("lwin.ls", 32'(left_score), 32'd1);
      chk("lwin.rs", 32'(right_score), 32'd1);
      for (int i = 0; i < RC; i++) step("ldark", 0, 0);

      for (int i = 0; i < 5; i++) step("rwin2", 0, 1);
      for (int i = 0; i < RC; i++) step("rdark2", 0, 0);
      for (int i = 0; i < 5; i++) step("rwin3", 0, 1);
      chk("match.rs", 32'(right_score), 32'd3);
      chk("match.mo", 32'(match_over), 32'd1);
      chk("match.mw", 32'(match_winner), 32'h2);
      for (int i = 0; i < 10; i++)
         step("done", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      chk("done.lit", 32'(lights), 32'h000);

      async_reset("rst_done");
      chk("rst_done.lit", 32'(lights), 32'h010);

      for (int i = 0; i < 5; i++) step("rwin4", 0, 1);
      step("won0", 0, 0);
      step("won1", 0, 0);
      async_reset("rst_won");
      step("post", 0, 1);
      chk("post.lit", 32'(lights), 32'h008);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
